// File: rtl/outport_uart_tx_pkg.sv
// Shared types and constants for the output-port UART transmitter.
package outport_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_t;

  localparam int BYTES_PER_WORD       = 4;
  localparam int BITS_PER_BYTE        = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud

endpackage

// File: rtl/outport_uart_tx_if.sv
// Output-port word stream in, serial line and status out.
interface outport_uart_tx_if;

  logic        wr_en;
  logic [31:0] wr_data;
  logic        tx;
  logic        busy;
  logic        full;
  logic        overflow;

  modport master (
    output wr_en,
    output wr_data,
    input  tx,
    input  busy,
    input  full,
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output tx,
    output busy,
    output full,
    output overflow
  );

endinterface

// File: rtl/outport_uart_tx_word_fifo.sv
// Synchronous 32-bit word FIFO; dout shows the head word combinationally.
// full is registered and reflects occupancy before any same-edge pop, so a push on full is always dropped.
module word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              din,
  output logic [31:0]              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          pushOk;
  logic          popOk;
  logic [CW-1:0] countNext;

  always_comb begin
    pushOk    = push && !full;
    popOk     = pop && !empty;
    countNext = count + CW'(pushOk) - CW'(popOk);
    empty     = (count == '0);
    dout      = mem[rdPtr];
  end

  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem[wrPtr] <= din;
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide, so wrap-around is free.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (pushOk) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (popOk) begin
        rdPtr <= rdPtr + AW'(1);
      end
      count <= countNext;
      full  <= (countNext == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/outport_uart_tx.sv
// Queues OUTPORT words and sends each as four 8N1 bytes, LSB byte first, on tx.
// A word pushed into an idle block starts its start bit one edge later; pushes on full are dropped and flagged.
module outport_uart_tx
  import outport_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  outport_uart_tx_if.slave   port
);

  localparam int BW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int BIW = $clog2(BITS_PER_BYTE);
  localparam int YW  = $clog2(BYTES_PER_WORD);

  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BIW-1:0] LAST_BIT  = BIW'(BITS_PER_BYTE - 1);
  localparam logic [YW-1:0]  LAST_BYTE = YW'(BYTES_PER_WORD - 1);

  txState_t       state;
  logic [BW-1:0]  baudCnt;
  logic [BIW-1:0] bitIdx;
  logic [YW-1:0]  byteIdx;
  logic [31:0]    shiftReg;
  logic [7:0]     byteReg;
  logic           txReg;
  logic           busyReg;
  logic           ovfReg;

  logic           fifoPop;
  logic           fifoFull;
  logic           fifoEmpty;
  logic [CW-1:0]  fifoCount;
  logic [31:0]    fifoDout;

  logic           baudLast;
  logic           wordDone;
  logic           pushOk;
  logic           goIdle;
  logic [CW-1:0]  countNext;

  word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clock),
    .rstN  (Reset),
    .push  (port.wr_en),
    .pop   (fifoPop),
    .din   (port.wr_data),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // wordDone marks the edges on which the FSM is ready to take a fresh word.
  always_comb begin
    baudLast  = (baudCnt == BAUD_LAST);
    wordDone  = (state == IDLE) ||
                ((state == STOP) && baudLast && (byteIdx == LAST_BYTE));
    fifoPop   = wordDone && !fifoEmpty;
    goIdle    = wordDone && fifoEmpty;
    pushOk    = port.wr_en && !fifoFull;
    countNext = fifoCount + CW'(pushOk) - CW'(fifoPop);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      byteIdx  <= '0;
      shiftReg <= '0;
      byteReg  <= '0;
      txReg    <= 1'b1;
      busyReg  <= 1'b0;
      ovfReg   <= 1'b0;
    end else begin
      if (port.wr_en && fifoFull) begin
        ovfReg <= 1'b1;
      end
      busyReg <= !goIdle || (countNext != '0);

      case (state)
        IDLE: begin
          txReg   <= 1'b1;
          baudCnt <= '0;
          if (!fifoEmpty) begin
            shiftReg <= fifoDout;
            byteIdx  <= '0;
            txReg    <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (baudLast) begin
            baudCnt <= '0;
            byteReg <= shiftReg[7:0];
            bitIdx  <= '0;
            txReg   <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + BW'(1);
          end
        end

        DATA: begin
          if (baudLast) begin
            baudCnt <= '0;
            if (bitIdx == LAST_BIT) begin
              txReg <= 1'b1;
              state <= STOP;
            end else begin
              bitIdx  <= bitIdx + BIW'(1);
              txReg   <= byteReg[1];
              byteReg <= byteReg >> 1;
            end
          end else begin
            baudCnt <= baudCnt + BW'(1);
          end
        end

        STOP: begin
          if (baudLast) begin
            baudCnt <= '0;
            if (byteIdx != LAST_BYTE) begin
              shiftReg <= shiftReg >> BITS_PER_BYTE;
              byteIdx  <= byteIdx + YW'(1);
              txReg    <= 1'b0;
              state    <= START;
            end else if (!fifoEmpty) begin
              shiftReg <= fifoDout;
              byteIdx  <= '0;
              txReg    <= 1'b0;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt + BW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign port.tx       = txReg;
  assign port.busy     = busyReg;
  assign port.full     = fifoFull;
  assign port.overflow = ovfReg;

endmodule

// File: tb/tb_outport_uart_tx.sv
// Bench for outport_uart_tx: word-level timing model plus a software UART receiver on tx.
module tb_outport_uart_tx;

  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int WORD_CYC = 40 * CPB;

  logic Clock = 1'b0;
  logic Reset;

  outport_uart_tx_if ifc ();

  outport_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .port  (ifc)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // Reference model: queued words, cycles left on the word being sent.
  logic [31:0] mq[$];
  logic [31:0] acc[$];
  logic [31:0] curWord = '0;
  int          txLeft  = 0;
  logic        mOvf    = 1'b0;

  // Software receiver state.
  logic [7:0]  rxQ[$];
  logic [7:0]  expQ[$];
  logic [7:0]  rxByte;
  logic        rxAct = 1'b0;
  int          rxPh  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic modelEdge(input logic en, input logic [31:0] d, input logic rst);
    int  preSize;
    logic popNow;
    if (rst) begin
      mq.delete();
      txLeft = 0;
      mOvf   = 1'b0;
      rxAct  = 1'b0;
      return;
    end
    preSize = mq.size();
    if (txLeft > 0) txLeft--;
    popNow = (txLeft == 0) && (preSize > 0);
    if (en) begin
      if (preSize < DEPTH) begin
        mq.push_back(d);
        acc.push_back(d);
      end else begin
        mOvf = 1'b1;
      end
    end
    if (popNow) begin
      curWord = mq.pop_front();
      txLeft  = WORD_CYC;
    end
  endtask

  function automatic logic modelTx();
    int p, b, k;
    if (txLeft == 0) return 1'b1;
    p = WORD_CYC - txLeft;
    b = (p / CPB) % 10;
    k = p / (10 * CPB);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return curWord[k*8 + b - 1];
  endfunction

  task automatic rxSample(input logic b);
    int idx;
    if (rxAct) begin
      rxPh++;
      if (rxPh >= CPB + CPB/2 && rxPh <= 8*CPB + CPB/2 && ((rxPh - CPB/2) % CPB) == 0) begin
        idx = (rxPh - CPB/2) / CPB - 1;
        rxByte[idx] = b;
      end
      if (rxPh == 9*CPB + CPB/2) begin
        chk("stop_bit", b, 1);
        rxQ.push_back(rxByte);
      end
      if (rxPh == 10*CPB - 1) rxAct = 1'b0;
    end else if (b == 1'b0) begin
      rxAct = 1'b1;
      rxPh  = 0;
    end
  endtask

  task automatic step(input logic en, input logic [31:0] d, input logic rst);
    ifc.wr_en   = en;
    ifc.wr_data = d;
    Reset       = !rst;
    @(posedge Clock);
    modelEdge(en, d, rst);
    #1;
    chk("tx",       ifc.tx,       modelTx());
    chk("busy",     ifc.busy,     (txLeft > 0) || (mq.size() > 0));
    chk("full",     ifc.full,     mq.size() == DEPTH);
    chk("overflow", ifc.overflow, mOvf);
    rxSample(ifc.tx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic addWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) expQ.push_back(w[8*i +: 8]);
  endtask

  task automatic checkRx(input string tag);
    int n;
    chk({tag, "_count"}, rxQ.size(), expQ.size());
    n = (rxQ.size() < expQ.size()) ? rxQ.size() : expQ.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, rxQ[i], expQ[i]);
    rxQ.delete();
    expQ.delete();
  endtask

  initial begin
    logic [31:0] w [6];
    int n;

    Reset       = 1'b0;
    ifc.wr_en   = 1'b0;
    ifc.wr_data = '0;

    // Reset state and quiet line
    repeat (3) step(1'b0, 32'h0, 1'b1);
    chk("rst_tx", ifc.tx, 1);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_full", ifc.full, 0);
    chk("rst_ovf", ifc.overflow, 0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'h0, 1'b0);
      chk("idle_tx", ifc.tx, 1);
    end

    // Single word, busy falls 161 edges after the push edge
    step(1'b1, 32'h0000_00A5, 1'b0);
    n = 0;
    do begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end while (ifc.busy && n < 400);
    chk("busy_fall", n, 161);
    addWord(32'h0000_00A5);
    checkRx("single");

    // Byte order
    step(1'b1, 32'h4433_2211, 1'b0);
    idle(170);
    expQ = '{8'h11, 8'h22, 8'h33, 8'h44};
    checkRx("order");

    // Full and overflow
    for (int i = 0; i < 6; i++) w[i] = $urandom;
    for (int i = 0; i < 5; i++) step(1'b1, w[i], 1'b0);
    chk("full_after5", ifc.full, 1);
    chk("noovf_after5", ifc.overflow, 0);
    step(1'b1, w[5], 1'b0);
    chk("ovf_after6", ifc.overflow, 1);
    idle(5 * WORD_CYC + 20);
    for (int i = 0; i < 5; i++) addWord(w[i]);
    checkRx("overflow");
    chk("ovf_sticky", ifc.overflow, 1);
    repeat (3) step(1'b0, 32'h0, 1'b1);
    chk("ovf_cleared", ifc.overflow, 0);

    // Back-to-back words
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 32'h0102_0304, 1'b0);
    idle(2 * WORD_CYC + 20);
    expQ = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
    checkRx("b2b");

    // Reset during bit 3 of byte 1 with two words still queued
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      step(1'b1, w[i], 1'b0);
    end
    idle(56);
    chk("mid_rx_count", rxQ.size(), 1);
    if (rxQ.size() > 0) chk("mid_rx_byte0", rxQ[0], w[0][7:0]);
    rxQ.delete();
    step(1'b0, 32'h0, 1'b1);
    chk("mid_rst_tx", ifc.tx, 1);
    chk("mid_rst_busy", ifc.busy, 0);
    chk("mid_rst_full", ifc.full, 0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_005A, 1'b0);
    idle(170);
    expQ = '{8'h5A, 8'h00, 8'h00, 8'h00};
    checkRx("post_reset");

    // Random push traffic against the model
    acc.delete();
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 29) == 0), $urandom, 1'b0);
    end
    idle(5 * WORD_CYC + 100);
    foreach (acc[i]) addWord(acc[i]);
    checkRx("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/outport_uart_tx.md
Name: outport_uart_tx

Overview:
- Consumer side of the CPU output port.
- Captures each 32-bit word the datapath writes to OUTPORT on the OUTPORTin strobe and queues it in a small word FIFO.
- Serialises each queued word as four 8N1 UART bytes, least-significant byte first, on a single tx line.
- Lets output-port traffic leave the board alongside the seven-segment display.

Parameters:
- CLKS_PER_BIT, 434, Clock cycles per UART bit (50 MHz / 115200); legal values are 2 and above.
- FIFO_DEPTH, 4, number of 32-bit words buffered; must be a power of two, 2 and above.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clock.
- wr_en  input  1  push strobe, tied to OUTPORTin; one word per cycle held high.
- wr_data  input  32  word to queue, tied to busMuxOut.
- tx  output  1  UART serial out; idles high.
- busy  output  1  high whenever the FIFO is non-empty or the FSM is not in IDLE.
- full  output  1  registered; high when the FIFO holds FIFO_DEPTH words.
- overflow  output  1  sticky flag; set when a push is dropped, cleared only by Reset.

Behaviour:
- Reset (Reset=0 at an edge) values:
  - tx=1, busy=0, full=0, overflow=0.
  - FIFO pointers and count = 0, FSM=IDLE, baud counter=0, bit index=0, byte index=0.
  - Reset mid-frame aborts the frame; tx returns high at that edge. Queued words are discarded.
- Push: on an edge with wr_en=1 and full=0, wr_data is written at the write pointer and count increments.
  - The write pointer wraps modulo FIFO_DEPTH.
- Push when full: full is evaluated before any same-cycle pop. The word is dropped and overflow is set to 1, even if a pop occurs on the same edge.
- Pop: occurs only on the edge where the FSM loads a new word. The read pointer wraps modulo FIFO_DEPTH.
- Simultaneous push (not full) and pop: count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty at an edge, pop the word into a 32-bit shift register, set byte index=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles. Load byte = shift register [7:0] and go to DATA.
  - DATA: tx = current bit, LSB first, CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then:
    - if byte index < 3: shift the word right by 8, increment byte index, go to START (no idle gap);
    - else if the FIFO is non-empty: pop the next word, set byte index=0, go to START (no idle gap);
    - else go to IDLE.
- Latency: a word pushed at edge N is popped at edge N+1 if the FSM is IDLE. tx goes low after edge N+1.
- Timing: one byte = 10*CLKS_PER_BIT cycles; one word = 40*CLKS_PER_BIT cycles.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets to 0 on each state or bit transition.
- full updates on the same edge as the push or pop that changes count.
- tx, full and busy are registered outputs; overflow is a registered sticky flag.

Decomposition:
- Package outport_uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - BYTES_PER_WORD=4, BITS_PER_BYTE=8;
  - the default CLKS_PER_BIT constant.
- One sub-module, word_fifo: synchronous FIFO, parameter DEPTH, 32-bit data.
  - Ports: push, pop, din, dout, full, empty, count.
  - Exposes pre-pop full so the drop rule above holds.
- The FSM and baud/bit counters stay in outport_uart_tx.

Test Plan:
- CLKS_PER_BIT=4 for all tests.
- Reset: hold Reset=0 three cycles -> tx=1, busy=0, full=0, overflow=0; tx stays 1 for 20 idle cycles.
- Single word: push 0x000000A5 at edge N -> tx=0 from edge N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop=1.
  - Next three bytes decode to 0x00; busy falls 160 cycles after edge N+1.
- Byte order: push 0x44332211 -> bytes decoded from tx are 0x11, 0x22, 0x33, 0x44, with no gap between stop and next start.
- Full and overflow:
  - Push 5 words on consecutive cycles while idle. The first is popped, so 4 are queued and full=1; no drop.
  - A 6th push is dropped and overflow=1.
  - Decoded stream contains exactly the first 5 words in order; overflow stays 1 until Reset.
- Back-to-back words: push 0xDEADBEEF and 0x01020304 -> 8 bytes EF BE AD DE 04 03 02 01, 320 cycles of contiguous framing, no idle bit between words.
- Reset mid-frame: assert Reset=0 during bit 3 of byte 1 of a word with two words queued -> tx=1 at that edge, FIFO empty, busy=0.
  - After release, a new push of 0x0000005A transmits cleanly as 5A 00 00 00.
